// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and frame sizing.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bit periods in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts enable strobes within one bit period and flags the strobe that ends it.
// Holds while enable is low; clear forces the count back to zero.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign bit_end = enable && !clear && (count_reg == CNT_LAST);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = bit_end ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: ready/valid word intake, configurable data width,
// parity and stop bits, paced by an oversampling baud strobe.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] txDataIn,
  output logic                 txReady,
  output logic                 txDataOut,
  output logic                 busy,
  output logic                 txDone
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 1) begin : g_bad_oversample
    $error("uart_tx_frame: OVERSAMPLE must be at least 1");
  end

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic                 parity_reg, parity_next;
  logic                 line_reg, line_next;
  logic                 ready_reg, ready_next;
  logic                 done_reg, done_next;
  logic                 timer_clear;
  logic                 bit_end;

  // Holding the timer clear while idle means the acceptance-cycle strobe is never counted.
  assign timer_clear = (state_reg == ST_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (enable),
    .bit_end(bit_end)
  );

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    parity_next   = parity_reg;
    done_next     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (transmit && ready_reg) begin
          state_next    = ST_START;
          shift_next    = txDataIn;
          parity_next   = (^txDataIn) ^ (PARITY == PAR_ODD);
          bit_idx_next  = '0;
          stop_idx_next = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == LAST_DATA) begin
            bit_idx_next = '0;
            state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_reg == LAST_STOP) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            stop_idx_next = stop_idx_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Line level is registered from the next state so the pad never glitches.
    unique case (state_next)
      ST_START:  line_next = 1'b0;
      ST_DATA:   line_next = shift_next[0];
      ST_PARITY: line_next = parity_next;
      default:   line_next = 1'b1;
    endcase

    ready_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      parity_reg   <= 1'b0;
      line_reg     <= 1'b1;
      ready_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      parity_reg   <= parity_next;
      line_reg     <= line_next;
      ready_reg    <= ready_next;
      done_reg     <= done_next;
    end
  end

  assign txReady   = ready_reg;
  assign txDataOut = line_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign txDone    = done_reg;

endmodule
